// File: rtl/tick_gen_multi.sv
// Multi-channel programmable tick generator.
// Every channel divides clk by its own runtime divisor and drives a one-cycle
// strobe (tick) plus a toggle output (sq) that flips on each tick. Divisor
// writes land in a shadow register and become active only at a safe point:
// on a global sync, while the channel is disabled, or at its terminal count.
module tick_gen_multi #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CH_W        = 2,
  parameter int unsigned CNT_W       = 21,
  parameter int unsigned DEFAULT_DIV = 1666667
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [CNT_W-1:0]  wr_div,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] sq,
  output logic [NUM_CH-1:0] div_pending
);

  logic [CNT_W-1:0]  cnt     [NUM_CH];
  logic [CNT_W-1:0]  act_div [NUM_CH];
  logic [CNT_W-1:0]  shd_div [NUM_CH];
  logic [CNT_W-1:0]  period  [NUM_CH];
  logic [NUM_CH-1:0] pend;
  logic [NUM_CH-1:0] tc;
  logic [NUM_CH-1:0] activate;
  logic [NUM_CH-1:0] wr_hit;

  assign div_pending = pend;

  // Effective period, terminal count, shadow activation and write decode per channel
  always_comb begin
    tc       = '0;
    activate = '0;
    wr_hit   = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      period[i]   = (act_div[i] == '0) ? CNT_W'(1) : act_div[i];
      tc[i]       = en[i] && (cnt[i] == period[i] - CNT_W'(1));
      activate[i] = pend[i] && (sync || !en[i] || tc[i]);
      // Out-of-range channel indices never match any channel, so they are dropped
      wr_hit[i]   = wr_en && (32'(wr_ch) == i);
    end
  end

  // Per-channel counter, strobe, toggle and divisor shadow update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        cnt[i]     <= '0;
        act_div[i] <= CNT_W'(DEFAULT_DIV);
        shd_div[i] <= CNT_W'(DEFAULT_DIV);
      end
      pend <= '0;
      tick <= '0;
      sq   <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (sync) begin
          cnt[i]  <= '0;
          tick[i] <= 1'b0;
          sq[i]   <= 1'b0;
        end else if (!en[i]) begin
          tick[i] <= 1'b0;
        end else if (tc[i]) begin
          cnt[i]  <= '0;
          tick[i] <= 1'b1;
          sq[i]   <= ~sq[i];
        end else begin
          cnt[i]  <= cnt[i] + CNT_W'(1);
          tick[i] <= 1'b0;
        end

        if (activate[i]) begin
          act_div[i] <= shd_div[i];
          pend[i]    <= 1'b0;
        end
        // A write in the same cycle as activation is assigned last, so it wins:
        // act_div still takes the old shadow, while the new value stays pending.
        if (wr_hit[i]) begin
          shd_div[i] <= wr_div;
          pend[i]    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tick_gen_multi.sv
// Self-checking bench for tick_gen_multi: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// behavioural model of the channel rules.
module tb_tick_gen_multi;

  localparam int unsigned NCH = 4;
  localparam int unsigned CW  = 3;
  localparam int unsigned NW  = 8;
  localparam int unsigned DEF = 5;

  logic           clk = 1'b0;
  logic           rst;
  logic [NCH-1:0] en;
  logic           sync;
  logic           wr_en;
  logic [CW-1:0]  wr_ch;
  logic [NW-1:0]  wr_div;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] sq;
  logic [NCH-1:0] div_pending;

  int errors = 0;
  int checks = 0;

  tick_gen_multi #(
    .NUM_CH      (NCH),
    .CH_W        (CW),
    .CNT_W       (NW),
    .DEFAULT_DIV (DEF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .sync        (sync),
    .wr_en       (wr_en),
    .wr_ch       (wr_ch),
    .wr_div      (wr_div),
    .tick        (tick),
    .sq          (sq),
    .div_pending (div_pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  // Behavioural model: elapsed-count per channel with the four priority rules
  int unsigned    m_cnt [NCH];
  int unsigned    m_act [NCH];
  int unsigned    m_shd [NCH];
  logic [NCH-1:0] m_pend;
  logic [NCH-1:0] m_tick;
  logic [NCH-1:0] m_sq;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        m_cnt[i] <= 0;
        m_act[i] <= DEF;
        m_shd[i] <= DEF;
      end
      m_pend <= '0;
      m_tick <= '0;
      m_sq   <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        automatic int unsigned p = (m_act[i] == 0) ? 1 : m_act[i];
        automatic bit safe_point = sync || !en[i] || (m_cnt[i] == p - 1);
        if (sync) begin
          m_cnt[i] <= 0; m_tick[i] <= 1'b0; m_sq[i] <= 1'b0;
        end else if (!en[i]) begin
          m_tick[i] <= 1'b0;
        end else if (m_cnt[i] == p - 1) begin
          m_cnt[i] <= 0; m_tick[i] <= 1'b1; m_sq[i] <= ~m_sq[i];
        end else begin
          m_cnt[i] <= (m_cnt[i] + 1) % 256; m_tick[i] <= 1'b0;
        end
        if (m_pend[i] && safe_point) begin
          m_act[i]  <= m_shd[i];
          m_pend[i] <= 1'b0;
        end
      end
      if (wr_en && wr_ch < NCH) begin
        m_shd[wr_ch]  <= wr_div;
        m_pend[wr_ch] <= 1'b1;
      end
    end
  end

  // Every-cycle comparison of DUT outputs against the model
  always @(negedge clk) begin
    if (!rst) begin
      chk("model_tick", tick, m_tick);
      chk("model_sq", sq, m_sq);
      chk("model_pending", div_pending, m_pend);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int unsigned ch, input int unsigned d);
    wr_en  = 1'b1;
    wr_ch  = CW'(ch);
    wr_div = NW'(d);
    step();
    wr_en  = 1'b0;
  endtask

  initial begin
    int unsigned nt;
    rst = 1'b1; en = '0; sync = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_div = '0;
    repeat (2) step();
    chk("reset_tick", tick, 0);
    chk("reset_sq", sq, 0);
    chk("reset_pending", div_pending, 0);

    // Default period 5 on ch0, then divisor 3 written after edge 6
    en = 4'b0001; rst = 1'b0;
    nt = 0;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (n == 5 || n == 10 || n == 13 || n == 16 || n == 19) nt++;
      chk("ch0_tick", tick[0], (n == 5 || n == 10 || n == 13 || n == 16 || n == 19));
      chk("ch0_sq", sq[0], nt % 2);
      chk("ch0_pending", div_pending[0], (n >= 7 && n <= 9));
      chk("idle_ticks", tick[3:1], 0);
      if (n == 6) begin wr_en = 1'b1; wr_ch = 0; wr_div = 3; end
      if (n == 7) wr_en = 1'b0;
    end

    // Divisor 0 on disabled ch1 activates at once and behaves as period 1
    wr(1, 0);
    chk("ch1_pend_set", div_pending[1], 1);
    step();
    chk("ch1_pend_clear", div_pending[1], 0);
    en[1] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("ch1_tick_p1", tick[1], 1);
      chk("ch1_sq_p1", sq[1], k % 2);
    end

    // Periods 4 and 6 on ch0/ch2, realigned by sync
    wr(0, 4);
    wr(2, 6);
    en = 4'b0101; sync = 1'b1;
    step();
    sync = 1'b0;
    chk("sync_tick", tick, 0);
    chk("sync_sq", sq, 0);
    for (int n = 1; n <= 12; n++) begin
      step();
      chk("sync_ch0_tick", tick[0], (n % 4 == 0));
      chk("sync_ch2_tick", tick[2], (n % 6 == 0));
    end

    // ch0 disabled at cnt=2 holds its count
    repeat (2) step();
    en[0] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("disabled_tick", tick[0], 0);
    end
    en[0] = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("resume_tick", tick[0], (k == 2));
    end

    // Out-of-range channel write is dropped
    wr(5, 1);
    chk("bad_ch_pending", div_pending, 0);

    // Pending write discarded by asynchronous reset mid-count
    wr(0, 7);
    chk("pre_reset_pending", div_pending[0], 1);
    #3 rst = 1'b1;
    #1;
    chk("async_tick", tick, 0);
    chk("async_sq", sq, 0);
    chk("async_pending", div_pending, 0);
    step();
    en = 4'b0001; rst = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      step();
      chk("post_reset_tick", tick[0], (n == 5));
    end

    // Randomized traffic, checked by the model every cycle
    for (int c = 0; c < 3000; c++) begin
      en     = NCH'($urandom);
      en     = en | NCH'($urandom);
      sync   = ($urandom_range(0, 39) == 0);
      wr_en  = ($urandom_range(0, 5) == 0);
      wr_ch  = CW'($urandom_range(0, 7));
      wr_div = NW'($urandom_range(0, 9));
      step();
    end
    en = '0; sync = 1'b0; wr_en = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
